merge13: RTL
============

Name: merge13

Overview:
- Two-input merge node for the binary-tree NoC; the other direction of the 1-to-2 routing split.
- Accepts packets from In0/In1 and arbitrates round-robin between them.
- For each packet, emits a 1-bit source token on S, then the packet unchanged on Out.
- Token order matches the split node (S first, then data), so merge/split pairs stay symmetric; used on the upward (toward-root) path of each tree level.

Parameters:
- W, 9, packet width; destination address field is data[8:5], passed through unmodified.
- LAST_RST, 1'b1, reset value of the last-grant register; 1 means In0 wins the first tie.

Ports:
- CLK  input  1  clock
- _RESET  input  1  reset, asynchronous, active-low
- In0_data  input  W  packet from child 0
- In0_valid  input  1  In0 packet present
- In0_ready  output  1  In0 packet accepted this cycle
- In1_data  input  W  packet from child 1
- In1_valid  input  1  In1 packet present
- In1_ready  output  1  In1 packet accepted this cycle
- S_data  output  1  source token: 0 = In0, 1 = In1
- S_valid  output  1  token present
- S_ready  input  1  token consumer ready
- Out_data  output  W  merged packet
- Out_valid  output  1  packet present
- Out_ready  input  1  downstream ready

Behaviour:
- Handshake: a transfer occurs on a rising CLK edge when valid && ready. A producer holds valid and data stable until its transfer completes. merge13 never drops valid or changes S_data/Out_data while waiting.
- State machine, states IDLE, SEND_S, SEND_OUT. Registers: state, pkt[W-1:0], src, last.
- IDLE
  - Grant selection:
    - Only In0_valid: grant In0.
    - Only In1_valid: grant In1.
    - Both valid: grant the input != last.
  - Ready: In*_ready is driven combinationally = (state==IDLE) && granted input. At most one ready is high per cycle.
  - On accept: pkt <= granted data, src <= grant index, go to SEND_S.
  - No valid: stay in IDLE, both readies 0.
- SEND_S: S_valid=1, S_data=src. On S_ready: go to SEND_OUT.
- SEND_OUT: Out_valid=1, Out_data=pkt. On Out_ready: last <= src, go to IDLE.
- Throughput: a full packet takes 3 cycles minimum with both consumers always ready. Acceptance of the next packet happens in the IDLE cycle after the Out transfer. No pipelining overlap.
- Output gating: S_valid=0 outside SEND_S. Out_valid=0 outside SEND_OUT. Out_data/S_data hold the registered value at all times, and are 0 after reset.
- Reset values: state=IDLE, pkt=0, src=0, last=LAST_RST. All valid/ready outputs 0 until the first edge after _RESET deasserts (readies then follow IDLE grant logic).
- Reset mid-operation: a latched packet is discarded and no token is emitted.
- Arrival during service: an input that becomes valid during SEND_S/SEND_OUT waits. Fairness is applied at the next IDLE.
- Starvation bound: with both inputs continuously valid, grants strictly alternate.
- Stall: S_ready or Out_ready held low stalls indefinitely. No timeout, no reordering.

Optional Feature:
- Macro MERGE13_PKT_COUNT_EN.
- When defined:
  - Adds outputs Cnt0[15:0] and Cnt1[15:0].
  - Counters increment on each completed Out transfer from source 0/1 respectively.
  - Counters saturate at 16'hFFFF and reset to 0.
- When undefined: ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Package noc_pkg: W default, ADDR_MSB=8, ADDR_LSB=5, typedef enum logic [1:0] {IDLE, SEND_S, SEND_OUT} merge_state_t.
- One natural sub-module, rr_arb2:
  - Inputs: req[1:0], last, en.
  - Output: one-hot gnt[1:0].
  - Purely combinational; last is held in merge13.

Test Plan:
- Reset then single In0 packet 9'h0A5, S_ready=Out_ready=1 → In0_ready pulse, S_data=0 one cycle later, Out_data=9'h0A5 the cycle after.
- Both valid together, In0=9'h111 and In1=9'h1E2, held for 4 packets → tokens 0,1,0,1 and data order 111,1E2,111,1E2.
- Only In1 valid with packets 9'h1F0 then 9'h1F1 → both granted back to back despite last=1; S_data=1 both times.
- Out_ready held low 5 cycles in SEND_OUT → Out_valid and Out_data stable, In0_ready/In1_ready stay 0; completes on the first ready cycle.
- _RESET asserted during SEND_S → S_valid drops immediately; after release the next packet is routed normally and the old packet never appears.
- With MERGE13_PKT_COUNT_EN: 3 packets from In0 and 2 from In1 → Cnt0=3, Cnt1=2. Preloading a counter to 16'hFFFE and sending 3 packets leaves it at 16'hFFFF.

Source files
------------

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the binary-tree NoC merge/split nodes.
//   W_DEFAULT          : default packet width
//   ADDR_MSB/ADDR_LSB  : destination address field inside a packet (pass-through)
//   merge_state_t      : merge node sequencing states
//   sat_inc16          : saturating 16-bit increment helper
// -----------------------------------------------------------------------------
package noc_pkg;

   localparam int W_DEFAULT = 9;
   localparam int ADDR_MSB  = 8;
   localparam int ADDR_LSB  = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND_S   = 2'd1,
      SEND_OUT = 2'd2
   } merge_state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      if (val == 16'hFFFF) begin
         return 16'hFFFF;
      end else begin
         return val + 16'd1;
      end
   endfunction

endpackage

// File: rtl/merge13_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter, purely combinational.
//   req[1:0] : request per input
//   last     : index of the input served most recently (history kept by caller)
//   en       : grant enable; no grant is issued while low
//   gnt[1:0] : one-hot grant (or zero)
// On a tie the input that was NOT served last wins.
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       en,
   output logic [1:0] gnt
);

   // Grant selection: single requester wins outright, tie goes to !last.
   always_comb begin
      gnt = 2'b00;
      if (!en) begin
         gnt = 2'b00;
      end else begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/merge13.sv
// -----------------------------------------------------------------------------
// merge13
// Two-input merge node for the binary-tree NoC (upward path). Accepts one
// packet at a time from In0/In1 with round-robin arbitration, then emits a
// 1-bit source token on S followed by the unchanged packet on Out.
//
// Ports:
//   CLK, _RESET              clock, asynchronous active-low reset
//   In0_*/In1_*              child packet inputs (valid/ready handshake)
//   S_data/S_valid/S_ready   source token (0 = In0, 1 = In1)
//   Out_data/Out_valid/Out_ready  merged packet output
//   Cnt0/Cnt1                per-source completed-packet counters, saturating
//                            (present only when MERGE13_PKT_COUNT_EN is defined)
//
// Optional build macro: MERGE13_PKT_COUNT_EN
// -----------------------------------------------------------------------------
module merge13
   import noc_pkg::*;
#(
   parameter int   W        = W_DEFAULT,
   parameter logic LAST_RST = 1'b1
) (
   input  logic         CLK,
   input  logic         _RESET,
   input  logic [W-1:0] In0_data,
   input  logic         In0_valid,
   output logic         In0_ready,
   input  logic [W-1:0] In1_data,
   input  logic         In1_valid,
   output logic         In1_ready,
   output logic         S_data,
   output logic         S_valid,
   input  logic         S_ready,
   output logic [W-1:0] Out_data,
   output logic         Out_valid,
   input  logic         Out_ready
`ifdef MERGE13_PKT_COUNT_EN
   ,
   output logic [15:0]  Cnt0,
   output logic [15:0]  Cnt1
`endif
);

   merge_state_t state_r;
   merge_state_t state_s;
   logic [W-1:0] pkt_r;
   logic         src_r;
   logic         last_r;
   logic         live_r;    // low until the first clock edge after reset release
   logic         arb_en_s;
   logic [1:0]   gnt_s;
   logic         accept_s;
   logic         out_done_s;

   // Readies must stay low during reset and up to the first edge afterwards,
   // so arbitration is held off until live_r has been set once.
   assign arb_en_s   = live_r && (state_r == IDLE);
   assign accept_s   = (gnt_s != 2'b00);
   assign out_done_s = (state_r == SEND_OUT) && Out_ready;

   rr_arb2 u_arb (
      .req (({In1_valid, In0_valid})),
      .last(last_r),
      .en  (arb_en_s),
      .gnt (gnt_s)
   );

   assign In0_ready = gnt_s[0];
   assign In1_ready = gnt_s[1];
   assign S_valid   = (state_r == SEND_S);
   assign S_data    = src_r;
   assign Out_valid = (state_r == SEND_OUT);
   assign Out_data  = pkt_r;

   // Next-state logic: token first, then packet, then back to arbitration.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = SEND_S;
            end else begin
               state_s = IDLE;
            end
         end
         SEND_S: begin
            if (S_ready) begin
               state_s = SEND_OUT;
            end else begin
               state_s = SEND_S;
            end
         end
         SEND_OUT: begin
            if (Out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = SEND_OUT;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State register and arbitration-enable flag.
   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         state_r <= IDLE;
         live_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         live_r  <= 1'b1;
      end
   end

   // Packet/source latch on accept; fairness history updated on Out completion.
   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         pkt_r  <= '0;
         src_r  <= 1'b0;
         last_r <= LAST_RST;
      end else begin
         if (accept_s) begin
            pkt_r <= gnt_s[1] ? In1_data : In0_data;
            src_r <= gnt_s[1];
         end
         if (out_done_s) begin
            last_r <= src_r;
         end
      end
   end

`ifdef MERGE13_PKT_COUNT_EN
   logic [15:0] cnt0_r;
   logic [15:0] cnt1_r;

   assign Cnt0 = cnt0_r;
   assign Cnt1 = cnt1_r;

   // Per-source completed-packet counters.
   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         cnt0_r <= 16'h0000;
         cnt1_r <= 16'h0000;
      end else if (out_done_s) begin
         if (src_r) begin
            cnt1_r <= sat_inc16(cnt1_r);
         end else begin
            cnt0_r <= sat_inc16(cnt0_r);
         end
      end
   end
`endif

endmodule
